// File: rtl/sw_pkg.sv
// Shared types for the 4-port switch: port count, arbiter states,
// port vectors and port indices.
package sw_pkg;

  localparam int NPORT = 4;
  localparam int PTRW  = $clog2(NPORT);

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  typedef logic [NPORT-1:0] portvec_t;
  typedef logic [PTRW-1:0]  portidx_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req scanning from ptr.
// Ports: req, ptr in; one-hot gnt and its index idx out.
module rr_pick
  import sw_pkg::*;
(
  input  portvec_t req,
  input  portidx_t ptr,
  output portvec_t gnt,
  output portidx_t idx
);

  portidx_t j;

  // Scan farthest offset first so the nearest hit to ptr wins.
  // NPORT is a power of two, so index wrap is free.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = '0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      j = ptr + portidx_t'(k);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/out_arb.sv
// Per-output wormhole round-robin arbiter; ack drives the crossbar select.
// Ports: clk, rst_n, req/vld/tail/ordy in; ack, ovld, pop, tmo_err out.
// Optional stall timeout is built when ARB_TIMEOUT_EN is defined.
module out_arb
  import sw_pkg::*;
#(
  parameter int TMO_CYC = 255,
  parameter int TMOW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NPORT-1:0] req,
  input  logic [NPORT-1:0] vld,
  input  logic [NPORT-1:0] tail,
  input  logic             ordy,
  output logic [NPORT-1:0] ack,
  output logic             ovld,
  output logic [NPORT-1:0] pop,
  output logic             tmo_err
);

  if (TMO_CYC >= 2 ** TMOW) begin : g_bad_tmo
    $error("TMO_CYC must be below 2**TMOW");
  end

  arb_state_t state, state_n;
  portvec_t   ack_n;
  portidx_t   ptr, ptr_n;
  portvec_t   pick_gnt;
  portidx_t   pick_idx;
  logic       fire;
  logic       tail_fire;
  logic       tmo_hit;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign pop       = ack & vld & {NPORT{ordy}};
  assign ovld      = |(ack & vld);
  assign fire      = |pop;
  assign tail_fire = |(pop & tail);

`ifdef ARB_TIMEOUT_EN
  logic [TMOW-1:0] tmo_cnt;

  assign tmo_hit = (state == ARB_GRANT) &&
                   (tmo_cnt == TMOW'(TMO_CYC));
  assign tmo_err = tmo_hit && !tail_fire;

  // Counts stalled cycles of the current grant only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == ARB_GRANT &&
                 state_n == ARB_GRANT &&
                 !fire) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign tmo_err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    ack_n   = ack;
    ptr_n   = ptr;
    unique case (state)
      ARB_IDLE: begin
        if (|req) begin
          ack_n   = pick_gnt;
          ptr_n   = pick_idx + 1'b1;
          state_n = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (tail_fire || tmo_hit) begin
          ack_n   = '0;
          state_n = ARB_IDLE;
        end
      end
      default: begin
        ack_n   = '0;
        state_n = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      ack   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ack   <= ack_n;
      ptr   <= ptr_n;
    end
  end

endmodule
